esp32_rom_loader: RTL
=====================

// Module: esp32_rom_loader
// PURPOSE
//  Converts the ESP32 SPI byte-write stream into 16-bit SDRAM word writes while a SNES ROM loads.
//  Upstream of the SDRAM request mux, which takes load_addr/load_data/load_wr until load_done.
//  Derives rom_type, rom_mask and ram_mask for the SNES core.
//  Owns load_done, which holds the SNES core in reset.
// PARAMETERS
//  FIFO_DEPTH  4      word FIFO entries, power of 2, minimum 2
//  CTRL_PAGE   8'hFF  spi_addr[31:24] value that selects the control register
//  DEF_TYPE    8'h00  rom_type used when header detect is compiled out
//  DEF_RAMMASK 24'h7FF ram_mask used when header detect is compiled out
// PORTS
//  clk_sys    in   1   system clock; all logic on its rising edge
//  reset_n    in   1   asynchronous reset, active low
//  spi_wr     in   1   one-cycle strobe: spi_addr/spi_data valid
//  spi_addr   in   32  [31:24] page; [23:0] ROM byte address
//  spi_data   in   8   byte written
//  mem_busy   in   1   SDRAM busy; a write is not issued while this is high
//  load_addr  out  25  SDRAM byte address {1'b0, waddr[23:1], 1'b0}
//  load_data  out  16  {odd byte, even byte}; SNES data is little-endian
//  load_wr    out  1   one-cycle word write request
//  load_done  out  1   high only in DONE
//  rom_type   out  8   8'h00 LoROM, 8'h01 HiROM
//  rom_mask   out  24  byte mask covering the loaded image
//  ram_mask   out  24  BSRAM byte mask; 0 means no BSRAM
//  overflow   out  1   sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset values
//   - state IDLE; load_wr=0, load_done=0, overflow=0.
//   - rom_mask=0, ram_mask=0, rom_type=0, FIFO empty, low byte=8'hFF.
//   - Reset asserted mid-load aborts immediately; no partial write is issued.
//  Control write: spi_wr with page==CTRL_PAGE; only spi_data[0] is used.
//  State machine
//   - IDLE/DONE + ctrl 1 -> LOADING.
//     On entry: clear FIFO, rom_mask, overflow, header capture; low byte=8'hFF.
//   - IDLE + ctrl 0 -> DONE (run with no ROM).
//   - LOADING + ctrl 0 -> DRAIN. A pending even byte is pushed as {8'h00, low}.
//   - LOADING + ctrl 1 is ignored.
//   - DRAIN -> DONE on the first cycle with FIFO empty, mem_busy=0 and load_wr=0.
//  ROM byte handling: spi_wr with page != CTRL_PAGE, honoured in LOADING only
//   - All states: rom_mask |= smear(addr[23:0]); smear sets every bit at or below the MSB.
//   - Even address: latch low byte and its word address; set pending.
//   - Odd address: push {spi_data, low} at addr[23:1]; clear pending; low byte=8'hFF.
//     Word address comes from the odd byte, even if no matching even byte arrived.
//   - Even byte while pending: old pending word is pushed as {8'h00, old low}; new byte latched.
//  FIFO
//   - Push while full: word dropped, overflow set; FIFO contents unchanged.
//   - Push and pop in the same cycle on a full FIFO is legal and does not set overflow.
//  Write issue
//   - Condition: FIFO non-empty, mem_busy=0, load_wr=0 in the previous cycle.
//   - When met: load_wr=1 for one cycle, load_addr/load_data from the FIFO head, pop that cycle.
//   - load_wr is never high on two consecutive cycles.
//   - load_addr/load_data hold the last value when load_wr=0.
//   - Latency: byte strobe to load_wr is at least 2 cycles.
//  Outputs rom_type/rom_mask/ram_mask are registered and stable while load_done=1.
// CONFIGURATION
//  ROM_HEADER_DETECT_EN defined
//   - Capture bytes at 0x007FD5/7FD8 (Lo) and 0x00FFD5/FFD8 (Hi) while loading.
//   - Hi selected if Hi map byte [7:5]==3'b001 and [3:0] is 1 or 5; otherwise Lo.
//   - rom_type = 8'h01 when Hi is selected, else 8'h00.
//   - ram_mask = 0 if size==0, else (24'h400 << min(size,7)) - 1.
//   - rom_type and ram_mask update on entry to DONE.
//  ROM_HEADER_DETECT_EN undefined
//   - rom_type=DEF_TYPE, ram_mask=DEF_RAMMASK; no header capture logic.
//  rom_mask is always computed from the loaded addresses.
// TESTING
//  1. ctrl 1; bytes 0x00=AA, 0x01=BB; ctrl 0.
//     -> one load_wr, addr 0, data 16'hBBAA, then load_done=1; rom_mask=24'h1.
//  2. mem_busy=1 while 8 words stream in (FIFO_DEPTH=4).
//     -> overflow=1; exactly 4 writes after busy drops; no back-to-back load_wr.
//  3. Even byte 0x10=5A, then ctrl 0.
//     -> write addr 0x10, data 16'h005A, then DONE.
//  4. Load 512 KiB with 0xFFD5=21, 0xFFD8=03 (DETECT_EN).
//     -> rom_type=8'h01, rom_mask=24'h07FFFF, ram_mask=24'h001FFF.
//  5. reset_n low mid-stream with FIFO non-empty.
//     -> load_wr=0 and load_done=0 at once; after release, a new load behaves as in test 1.
//  6. In DONE, ctrl 1 then ctrl 0 with no bytes.
//     -> load_done drops then rises; rom_mask=0; no load_wr.

Source files
------------

// File: rtl/esp32_rom_loader.sv
// esp32_rom_loader: packs the ESP32 SPI byte stream into 16-bit SDRAM word
// writes while a SNES ROM loads, tracks the ROM/BSRAM masks and ROM mapping,
// and holds the SNES core in reset (load_done low) until the load completes.
// Optional feature macro: ROM_HEADER_DETECT_EN (derive rom_type/ram_mask from
// the cartridge header instead of the DEF_TYPE/DEF_RAMMASK parameters).
module esp32_rom_loader #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [7:0]  CTRL_PAGE   = 8'hFF,
    parameter logic [7:0]  DEF_TYPE    = 8'h00,
    parameter logic [23:0] DEF_RAMMASK = 24'h7FF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        spi_wr,
    input  logic [31:0] spi_addr,
    input  logic [7:0]  spi_data,
    input  logic        mem_busy,
    output logic [24:0] load_addr,
    output logic [15:0] load_data,
    output logic        load_wr,
    output logic        load_done,
    output logic [7:0]  rom_type,
    output logic [23:0] rom_mask,
    output logic [23:0] ram_mask,
    output logic        overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOADING, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic ctrl_wr, byte_wr, flush, start_load, enter_done;
    logic pending;
    logic [7:0]  low_byte;
    logic [22:0] pend_addr;
    logic        push, push_ok, pop, full;
    logic [22:0] push_addr;
    logic [15:0] push_data;
    logic [22:0] fa [FIFO_DEPTH];
    logic [15:0] fd [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic [7:0]  type_nxt;
    logic [23:0] rmask_nxt;

    // Every bit at or below the highest set address bit.
    function automatic logic [23:0] smear(input logic [23:0] a);
        logic [23:0] m;
        m[23] = a[23];
        for (int i = 22; i >= 0; i--) m[i] = a[i] | m[i+1];
        return m;
    endfunction

    assign ctrl_wr    = spi_wr && (spi_addr[31:24] == CTRL_PAGE);
    assign byte_wr    = spi_wr && (spi_addr[31:24] != CTRL_PAGE) && (state == LOADING);
    assign flush      = (state == LOADING) && ctrl_wr && !spi_data[0];
    assign start_load = (state_nxt == LOADING) && (state != LOADING);
    assign enter_done = (state_nxt == DONE) && (state != DONE);
    assign full       = (count == FULL_CNT);
    assign pop        = (count != '0) && !mem_busy && !load_wr;
    assign push_ok    = push && (!full || pop);
    assign load_done  = (state == DONE);

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: control writes start/stop the load; DRAIN waits for the FIFO to empty.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl_wr) state_nxt = spi_data[0] ? LOADING : DONE;
            LOADING: if (ctrl_wr && !spi_data[0]) state_nxt = DRAIN;
            DRAIN:   if ((count == '0) && !mem_busy && !load_wr) state_nxt = DONE;
            DONE:    if (ctrl_wr && spi_data[0]) state_nxt = LOADING;
            default: state_nxt = IDLE;
        endcase
    end

    // Word assembly: odd bytes complete a word; a lone even byte is flushed with a zero high byte.
    always_comb begin
        push      = 1'b0;
        push_addr = pend_addr;
        push_data = {8'h00, low_byte};
        if (byte_wr) begin
            if (spi_addr[0]) begin
                push      = 1'b1;
                push_addr = spi_addr[23:1];
                push_data = {spi_data, low_byte};
            end else begin
                push = pending;
            end
        end else if (flush) begin
            push = pending;
        end
    end

    // Byte latch, pending flag and sticky overflow.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            low_byte  <= 8'hFF;
            pend_addr <= '0;
            pending   <= 1'b0;
            overflow  <= 1'b0;
        end else if (start_load) begin
            low_byte <= 8'hFF;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push && full && !pop) overflow <= 1'b1;
            if (byte_wr && !spi_addr[0]) begin
                low_byte  <= spi_data;
                pend_addr <= spi_addr[23:1];
                pending   <= 1'b1;
            end else if (byte_wr || flush) begin
                low_byte <= 8'hFF;
                pending  <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; a new load empties it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0; rp <= '0; count <= '0;
        end else if (start_load) begin
            wp <= '0; rp <= '0; count <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fa[wp] <= push_addr;
            fd[wp] <= push_data;
        end
    end

    // Write issue: one-cycle strobe from the FIFO head; address/data hold between writes.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            load_wr   <= 1'b0;
            load_addr <= '0;
            load_data <= '0;
        end else begin
            load_wr <= pop;
            if (pop) begin
                load_addr <= {1'b0, fa[rp], 1'b0};
                load_data <= fd[rp];
            end
        end
    end

    // ROM mask grows with every byte address seen during the load.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)     rom_mask <= '0;
        else if (start_load) rom_mask <= '0;
        else if (byte_wr) rom_mask <= rom_mask | smear(spi_addr[23:0]);
    end

`ifdef ROM_HEADER_DETECT_EN
    // Lo is the fallback mapping, so its map byte never needs to be kept.
    logic [7:0] hi_map, hi_size, lo_size, sel_size;
    logic       hi_sel;

    // Header byte capture during the load.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hi_map <= '0; hi_size <= '0; lo_size <= '0;
        end else if (start_load) begin
            hi_map <= '0; hi_size <= '0; lo_size <= '0;
        end else if (byte_wr) begin
            case (spi_addr[23:0])
                24'h00FFD5: hi_map  <= spi_data;
                24'h00FFD8: hi_size <= spi_data;
                24'h007FD8: lo_size <= spi_data;
                default: ;
            endcase
        end
    end

    // Map selection and BSRAM mask from the captured header.
    always_comb begin
        hi_sel    = (hi_map[7:5] == 3'b001) && ((hi_map[3:0] == 4'h1) || (hi_map[3:0] == 4'h5));
        sel_size  = hi_sel ? hi_size : lo_size;
        type_nxt  = {7'd0, hi_sel};
        rmask_nxt = '0;
        if (sel_size != 8'd0)
            rmask_nxt = (24'h400 << ((sel_size > 8'd7) ? 3'd7 : sel_size[2:0])) - 24'd1;
    end
`else
    assign type_nxt  = DEF_TYPE;
    assign rmask_nxt = DEF_RAMMASK;
`endif

    // Mapping outputs latch on entry to DONE and stay put while the core runs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rom_type <= '0;
            ram_mask <= '0;
        end else if (enter_done) begin
            rom_type <= type_nxt;
            ram_mask <= rmask_nxt;
        end
    end
endmodule
